// File: rtl/dphy_hs_pkg.sv
// Shared types and constants for the D-PHY HS transmit path.
package dphy_hs_pkg;

   localparam int unsigned HS_CNT_W  = 4;
   localparam int unsigned HS_BYTE_W = 8;
   localparam int unsigned HS_SLIP_W = 3;

   localparam logic [HS_BYTE_W-1:0] HS_SYNC_BYTE = 8'h1D;
   localparam logic [HS_BYTE_W-1:0] HS_ZERO_BYTE = 8'h00;

   typedef enum logic [2:0] {
      IDLE,
      ZERO,
      SYNC,
      DATA,
      TRAIL
   } hs_tx_state_t;

   // Trailer is the complement of the last serialized bit (bit 7), repeated.
   function automatic logic [HS_BYTE_W-1:0] hs_trailer_byte(input logic [HS_BYTE_W-1:0] last);
      return {HS_BYTE_W{~last[HS_BYTE_W-1]}};
   endfunction

endpackage

// File: rtl/hs_bit_shifter.sv
// Bit-slip datapath: delays the byte stream by slip_i bits using the previous byte as carry.
module hs_bit_shifter
   import dphy_hs_pkg::*;
(
   input  logic [HS_BYTE_W-1:0] cur_i,
   input  logic [HS_BYTE_W-1:0] prev_i,
   input  logic [HS_SLIP_W-1:0] slip_i,
   output logic [HS_BYTE_W-1:0] out_c
);

   // Upper byte of {cur,prev} << N equals (cur << N) | (prev >> (8-N)).
   always_comb begin
      out_c = HS_BYTE_W'(({cur_i, prev_i} << slip_i) >> HS_BYTE_W);
   end

endmodule

// File: rtl/hs_tx_sequencer.sv
// HS transmit sequencer: leader zeros, sync byte, PPI payload, trailer.
// Optional HS_TX_BITSLIP_EN adds TxSlip and a bit-delayed output stream.
module hs_tx_sequencer
   import dphy_hs_pkg::*;
#(
   parameter int unsigned ZERO_BYTES  = 2,
   parameter int unsigned TRAIL_BYTES = 2
) (
   input  logic                 TxByteClkHS,
   input  logic                 Rst_n,
   input  logic                 Enable,
   input  logic                 TxRequestHS,
   input  logic [HS_BYTE_W-1:0] TxDataHS,
`ifdef HS_TX_BITSLIP_EN
   input  logic [HS_SLIP_W-1:0] TxSlip,
`endif
   output logic                 TxReadyHS,
   output logic [HS_BYTE_W-1:0] DataHS,
   output logic                 HS_Active
);

   localparam logic [HS_CNT_W-1:0] ZERO_LOAD  = HS_CNT_W'(ZERO_BYTES - 1);
   localparam logic [HS_CNT_W-1:0] TRAIL_LOAD = HS_CNT_W'(TRAIL_BYTES - 1);

   hs_tx_state_t          state_q, state_d;
   logic [HS_CNT_W-1:0]   cnt_q, cnt_d;
   logic [HS_BYTE_W-1:0]  raw_q, raw_d;
   logic                  ready_q, ready_d;
   logic                  active_q, active_d;
   logic [HS_CNT_W-1:0]   trail_load_c;

`ifdef HS_TX_BITSLIP_EN
   logic [HS_SLIP_W-1:0]  slip_q, slip_d;
   logic [HS_BYTE_W-1:0]  data_q, data_d;
   logic [HS_BYTE_W-1:0]  shift_c;

   // Slip is latched only when a burst leaves IDLE and held until the next one.
   assign slip_d       = (state_q == IDLE && TxRequestHS) ? TxSlip : slip_q;
   assign trail_load_c = TRAIL_LOAD + HS_CNT_W'(slip_q != '0);

   hs_bit_shifter u_shift (
      .cur_i  (raw_d),
      .prev_i (raw_q),
      .slip_i (slip_q),
      .out_c  (shift_c)
   );

   assign data_d = active_d ? shift_c : HS_ZERO_BYTE;
`else
   assign trail_load_c = TRAIL_LOAD;
`endif

   // Next-state and unshifted byte stream.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      raw_d    = raw_q;
      ready_d  = ready_q;
      active_d = active_q;
      unique case (state_q)
         IDLE: begin
            raw_d    = HS_ZERO_BYTE;
            ready_d  = 1'b0;
            active_d = 1'b0;
            if (TxRequestHS) begin
               state_d  = ZERO;
               active_d = 1'b1;
               cnt_d    = ZERO_LOAD;
            end
         end
         ZERO: begin
            raw_d = HS_ZERO_BYTE;
            if (cnt_q == '0) begin
               state_d = SYNC;
               raw_d   = HS_SYNC_BYTE;
               ready_d = 1'b1;
            end else begin
               cnt_d = cnt_q - HS_CNT_W'(1);
            end
         end
         SYNC, DATA: begin
            if (TxRequestHS) begin
               state_d = DATA;
               raw_d   = TxDataHS;
               ready_d = 1'b1;
            end else begin
               state_d = TRAIL;
               raw_d   = hs_trailer_byte(raw_q);
               ready_d = 1'b0;
               cnt_d   = trail_load_c;
            end
         end
         TRAIL: begin
            if (cnt_q == '0) begin
               state_d  = IDLE;
               raw_d    = HS_ZERO_BYTE;
               active_d = 1'b0;
            end else begin
               cnt_d = cnt_q - HS_CNT_W'(1);
            end
         end
         default: begin
            state_d  = IDLE;
            raw_d    = HS_ZERO_BYTE;
            ready_d  = 1'b0;
            active_d = 1'b0;
            cnt_d    = '0;
         end
      endcase
   end

   always_ff @(posedge TxByteClkHS or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         raw_q    <= HS_ZERO_BYTE;
         ready_q  <= 1'b0;
         active_q <= 1'b0;
`ifdef HS_TX_BITSLIP_EN
         slip_q   <= '0;
         data_q   <= HS_ZERO_BYTE;
`endif
      end else if (Enable) begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         raw_q    <= raw_d;
         ready_q  <= ready_d;
         active_q <= active_d;
`ifdef HS_TX_BITSLIP_EN
         slip_q   <= slip_d;
         data_q   <= data_d;
`endif
      end
   end

   assign TxReadyHS = ready_q;
   assign HS_Active = active_q;
`ifdef HS_TX_BITSLIP_EN
   assign DataHS    = data_q;
`else
   assign DataHS    = raw_q;
`endif

endmodule

// File: tb/tb_hs_tx_sequencer.sv
// Self-checking bench for hs_tx_sequencer: burst table plus scoreboard, and hand-written reset cases.
module tb_hs_tx_sequencer;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       req;
   logic [7:0] tx_data;
   logic       rdy;
   logic [7:0] data;
   logic       act;
`ifdef HS_TX_BITSLIP_EN
   logic [2:0] slip;
`endif

   hs_tx_sequencer #(
      .ZERO_BYTES  (2),
      .TRAIL_BYTES (2)
   ) dut (
      .TxByteClkHS (clk),
      .Rst_n       (rst_n),
      .Enable      (en),
      .TxRequestHS (req),
      .TxDataHS    (tx_data),
`ifdef HS_TX_BITSLIP_EN
      .TxSlip      (slip),
`endif
      .TxReadyHS   (rdy),
      .DataHS      (data),
      .HS_Active   (act)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] d;
      logic       a;
      logic       r;
      logic [7:0] vid;
      logic [7:0] cyc;
   } exp_t;

   typedef struct packed {
      int unsigned      npay;
      logic [0:3][7:0]  pay;
      logic             hold;
      logic             trail_req;
      int               en_lo;
      logic [2:0]       slip;
      int unsigned      len;
      logic [0:11][7:0] exp_d;
      logic [0:11]      exp_a;
      logic [0:11]      exp_r;
   } vec_t;

   exp_t        sb_q[$];
   vec_t        vecs[$];
   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   function automatic exp_t mk_e(logic [7:0] d, logic a, logic r, int vid, int cyc);
      exp_t e;
      e.d   = d;
      e.a   = a;
      e.r   = r;
      e.vid = 8'(vid);
      e.cyc = 8'(cyc);
      return e;
   endfunction

   function automatic vec_t mkv(int unsigned npay, logic [0:3][7:0] pay, logic hold,
                                logic trq, int en_lo, logic [2:0] sl, int unsigned len,
                                logic [0:11][7:0] d, logic [0:11] a, logic [0:11] r);
      vec_t v;
      v.npay = npay;  v.pay = pay;   v.hold = hold; v.trail_req = trq;
      v.en_lo = en_lo; v.slip = sl;  v.len = len;
      v.exp_d = d;    v.exp_a = a;   v.exp_r = r;
      return v;
   endfunction

   task automatic cmp(input string nm, input exp_t e);
      n_vec++;
      if (data !== e.d || act !== e.a || rdy !== e.r) begin
         n_bad++;
         $display("FAIL %s: DataHS=%h HS_Active=%b TxReadyHS=%b, expected %h %b %b",
                  nm, data, act, rdy, e.d, e.a, e.r);
      end
   endtask

   // Scoreboard: one expected entry per driven cycle, checked mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         cmp($sformatf("v%0d.c%0d", e.vid, e.cyc), e);
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v, input int vid);
      int unsigned idx;
      bit          dropped;
      idx     = 0;
      dropped = 1'b0;
`ifdef HS_TX_BITSLIP_EN
      slip = v.slip;
`endif
      for (int c = 0; c < int'(v.len); c++) begin
         en = !(v.en_lo >= 0 && c >= v.en_lo && c < v.en_lo + 3);
         if (rdy && !dropped) begin
            if (idx < v.npay) begin
               req     = 1'b1;
               tx_data = v.pay[2'(idx)];
               if (en) idx++;
            end else begin
               req = 1'b0;
               if (en) dropped = 1'b1;
            end
         end else if (dropped) begin
            req = v.trail_req;
         end else begin
            req = (c == 0) || v.hold;
         end
         sb_q.push_back(mk_e(v.exp_d[c], v.exp_a[c], v.exp_r[c], vid, c));
         step();
      end
      en  = 1'b1;
      req = 1'b0;
      sb_q.push_back(mk_e(8'h00, 1'b0, 1'b0, vid, int'(v.len)));
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      rst_n   = 1'b0;
      en      = 1'b1;
      req     = 1'b0;
      tx_data = 8'h00;
`ifdef HS_TX_BITSLIP_EN
      slip    = 3'd0;
`endif
      #2;
      cmp("reset", mk_e(8'h00, 1'b0, 1'b0, 0, 0));
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      vecs.push_back(mkv(2, {8'hA5, 8'h3C, 8'h00, 8'h00}, 1'b1, 1'b0, -1, 3'd0, 8,
         {8'h00, 8'h00, 8'h1D, 8'hA5, 8'h3C, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
         12'b1111_1110_0000, 12'b0011_1000_0000));
      vecs.push_back(mkv(1, {8'h80, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b0, -1, 3'd0, 7,
         {8'h00, 8'h00, 8'h1D, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
         12'b1111_1100_0000, 12'b0011_0000_0000));
      vecs.push_back(mkv(0, {8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b0, -1, 3'd0, 6,
         {8'h00, 8'h00, 8'h1D, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
         12'b1111_1000_0000, 12'b0010_0000_0000));
      vecs.push_back(mkv(3, {8'h12, 8'hF0, 8'h7E, 8'h00}, 1'b1, 1'b1, -1, 3'd0, 9,
         {8'h00, 8'h00, 8'h1D, 8'h12, 8'hF0, 8'h7E, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00},
         12'b1111_1111_0000, 12'b0011_1100_0000));
      vecs.push_back(mkv(3, {8'hA5, 8'h3C, 8'h5A, 8'h00}, 1'b1, 1'b0, 4, 3'd0, 12,
         {8'h00, 8'h00, 8'h1D, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h3C, 8'h5A, 8'hFF, 8'hFF, 8'h00},
         12'b1111_1111_1110, 12'b0011_1111_1000));
`ifdef HS_TX_BITSLIP_EN
      vecs.push_back(mkv(1, {8'hFF, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b0, -1, 3'd3, 8,
         {8'h00, 8'h00, 8'hE8, 8'hF8, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
         12'b1111_1110_0000, 12'b0011_0000_0000));
`endif

      foreach (vecs[i]) run_vec(vecs[i], i);

      // Asynchronous reset while the trailer is on the line.
      req     = 1'b1;
      tx_data = 8'h3C;
      step(); step(); step();
      step();
      req = 1'b0;
      step();
      cmp("pre_async_rst", mk_e(8'hFF, 1'b1, 1'b0, 90, 0));
      rst_n = 1'b0;
      #1;
      cmp("async_rst", mk_e(8'h00, 1'b0, 1'b0, 90, 1));
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      cmp("post_rst_idle", mk_e(8'h00, 1'b0, 1'b0, 90, 2));

      run_vec(vecs[0], 99);

      if (sb_q.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/hs_tx_sequencer.md
Name: hs_tx_sequencer

Overview:
High-Speed transmit sequencer for the MIPI D-PHY transmitter lane, running in the TxByteClkHS domain.
- On a PPI TxRequestHS burst, emits HS-zero leader bytes, then the sync byte 8'h1D, then payload bytes under TxReadyHS handshake, then HS trailer bytes.
- Its byte stream is what the receiver-side HS sync detector locks onto: 8 consecutive zeros, then 8'h1D.
- Sits between the PPI byte interface and the HS serializer.

Parameters:
ZERO_BYTES, 2, number of 8'h00 leader bytes before sync; legal range 1..15.
TRAIL_BYTES, 2, number of trailer bytes after last payload byte; legal range 1..15.

Ports:
TxByteClkHS  input  1  HS byte clock; all logic on its rising edge.
Rst_n        input  1  reset; asynchronous, active-low.
Enable       input  1  clock-enable; when low, all state and outputs hold.
TxRequestHS  input  1  PPI HS transmit request; high for the whole burst.
TxDataHS     input  8  PPI payload byte, LSB transmitted first.
TxReadyHS    output 1  registered; high while the block accepts TxDataHS.
DataHS       output 8  registered byte to serializer.
HS_Active    output 1  registered; high from first leader byte through last trailer byte.

Behaviour:
- Reset (Rst_n low, any time, including mid-burst): state IDLE, DataHS=8'h00, TxReadyHS=0, HS_Active=0, byte counter=0. Takes effect immediately, without a clock edge.
- All transitions occur only on edges where Enable=1. An edge with Enable=0 changes nothing.
- FSM states: IDLE, ZERO, SYNC, DATA, TRAIL.
- IDLE:
  - Outputs low.
  - TxRequestHS=1 at edge E0 -> ZERO; DataHS=8'h00 and HS_Active=1 after E0; counter loaded with ZERO_BYTES-1.
- ZERO:
  - DataHS=8'h00.
  - Counter decrements each edge; at counter=0 -> SYNC.
  - Result: exactly ZERO_BYTES leader bytes, occupying edges E0..E(Z-1).
- SYNC:
  - After edge EZ, DataHS=8'h1D and TxReadyHS=1.
- SYNC or DATA, on each edge:
  - TxRequestHS=1: TxDataHS is consumed; DataHS<=TxDataHS; state DATA; TxReadyHS stays 1.
  - TxRequestHS=0: state TRAIL; TxReadyHS<=0; counter loaded with TRAIL_BYTES-1.
  - Trailer byte = {8{~last[7]}}, where last is the byte currently on DataHS. Bit 7 is the last serialized bit.
  - An empty burst (request dropped in SYNC) therefore gives trailer 8'hFF.
- Request dropped during ZERO: leader and sync still complete, then the burst behaves as empty (SYNC -> TRAIL).
- TRAIL:
  - Trailer byte held constant for TRAIL_BYTES cycles.
  - At counter=0 -> IDLE; DataHS<=8'h00, HS_Active<=0.
- Request re-asserted in TRAIL: ignored. A new burst starts only from IDLE, at the earliest on the edge after returning to IDLE.
- Latency:
  - First payload byte on DataHS after edge E(Z+1).
  - Each payload byte appears one edge after it is consumed.
- Throughput: one byte per cycle, no bubbles.

Optional Feature:
HS_TX_BITSLIP_EN
- Defined:
  - Adds input TxSlip [2:0] (sampled in IDLE at burst start, held for the burst).
  - The entire emitted bit stream is delayed by N=TxSlip bits: out = (cur<<N) | (prev>>(8-N)), with prev initialised to 8'h00.
  - When N!=0, one extra trailer byte is appended to flush the carry.
  - Used to exercise every receiver RxSyncPosition.
- Undefined: port absent, N=0 behaviour, no extra byte.

Decomposition:
- Package dphy_hs_pkg:
  - HS_SYNC_BYTE=8'h1D, HS_ZERO_BYTE=8'h00.
  - hs_tx_state_t enum {IDLE,ZERO,SYNC,DATA,TRAIL}.
  - Counter width constant HS_CNT_W=4.
- Sub-module hs_bit_shifter (the 16-bit carry/shift datapath), instantiated only under HS_TX_BITSLIP_EN.

Test Plan:
- Reset, then TxRequestHS=1 for payload {8'hA5,8'h3C}, defaults. Required: DataHS sequence 00,00,1D,A5,3C,FF,FF,00; HS_Active high for 7 cycles; TxReadyHS high for exactly 3 cycles.
- Payload {8'h80} (MSB=1). Required: trailer 00,00.
- Request pulsed for 1 cycle. Required: 00,00,1D,FF,FF, then IDLE. Next request accepted only from IDLE.
- Enable low for 3 cycles mid-DATA. Required: DataHS/state/TxReadyHS frozen; TxDataHS not consumed; stream resumes byte-exact.
- Rst_n low asynchronously during TRAIL. Required: outputs 0 immediately; next burst starts with a full leader.
- HS_TX_BITSLIP_EN, TxSlip=3, payload {8'hFF}. Required: DataHS 00,00,E8,F8,07,00,00 (1D<<3=E8; 1D>>5 | FF<<3=F8; FF>>5=07; then trailer 00,00 plus flush byte 00). Loop back through the receiver detector, which reports RxSyncPosition=3.
